// File: rtl/storage_pkg.sv
// Shared definitions for the arbitrated management SRAM port.
// Holds the FSM encoding, SRAM geometry and block-select width helper.
package storage_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StCapture,
    StResp
  } state_e;

  localparam int unsigned RAM_WORDS = 256;
  localparam int unsigned SRAM_AW   = 8;

  // Block-select width; a single block still gets one (ignored) select bit.
  function automatic int unsigned bsel_w(input int unsigned blocks);
    return (blocks <= 1) ? 1 : $clog2(blocks);
  endfunction

endpackage

// File: rtl/storage_arb_pick.sv
// Winner select between the Wishbone and housekeeping requesters,
// with a saturating counter that protects housekeeping from starvation.
module storage_arb_pick
  import storage_pkg::*;
#(
  parameter int unsigned HK_STARVE_MAX = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       idle_i,
  input  logic       wb_pend_i,
  input  logic       hk_pend_i,
  output logic       grant_o,
  output logic       grant_hk_o,
  output logic [3:0] starve_cnt_o
);

  localparam logic [3:0] StarveMax = 4'(HK_STARVE_MAX);

  logic [3:0] starve_q, starve_d;

  always_comb begin
    grant_o    = idle_i & (wb_pend_i | hk_pend_i);
    grant_hk_o = hk_pend_i & (~wb_pend_i | (starve_q == StarveMax));
    starve_d   = starve_q;
    if (grant_o) begin
      if (grant_hk_o || !hk_pend_i) begin
        starve_d = '0;
      end else if (starve_q != StarveMax) begin
        starve_d = starve_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  assign starve_cnt_o = starve_q;

endmodule

// File: rtl/storage_arbiter.sv
// Single-port management SRAM arbiter: Wishbone read/write and housekeeping
// read-only requests share one port with fixed latency and registered outputs.
module storage_arbiter
  import storage_pkg::*;
#(
  parameter int unsigned RAM_BLOCKS    = 2,
  parameter int unsigned HK_STARVE_MAX = 4,
  localparam int unsigned BSEL_W       = bsel_w(RAM_BLOCKS)
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic                      wbs_cyc_i,
  input  logic                      wbs_stb_i,
  input  logic                      wbs_we_i,
  input  logic [3:0]                wbs_sel_i,
  input  logic [31:0]               wbs_adr_i,
  input  logic [31:0]               wbs_dat_i,
  output logic                      wbs_ack_o,
  output logic [31:0]               wbs_dat_o,
  input  logic                      hk_req_i,
  input  logic [SRAM_AW+BSEL_W-1:0] hk_addr_i,
  output logic                      hk_valid_o,
  output logic [31:0]               hk_rdata_o,
  output logic [RAM_BLOCKS-1:0]     mem_ena_o,
  output logic [RAM_BLOCKS-1:0]     mem_wen_o,
  output logic [4*RAM_BLOCKS-1:0]   mem_wen_mask_o,
  output logic [SRAM_AW-1:0]        mem_addr_o,
  output logic [31:0]               mem_wdata_o,
  input  logic [32*RAM_BLOCKS-1:0]  mem_rdata_i
);

  state_e                  state_q;
  logic [BSEL_W-1:0]       blk_q;
  logic                    we_q;
  logic                    owner_hk_q;

  logic                    wb_pend;
  logic                    grant, grant_hk;
  logic [3:0]              starve_cnt;
  logic [BSEL_W-1:0]       wb_blk, hk_blk;
  logic [RAM_BLOCKS-1:0]   wb_onehot, hk_onehot;
  logic [4*RAM_BLOCKS-1:0] wb_mask;
  logic                    wb_wr_null;
  logic [31:0]             rdata_sel;

  assign wb_pend = wbs_cyc_i & wbs_stb_i;

  storage_arb_pick #(
    .HK_STARVE_MAX(HK_STARVE_MAX)
  ) u_pick (
    .clk_i       (wb_clk_i),
    .rst_i       (wb_rst_i),
    .idle_i      (state_q == StIdle),
    .wb_pend_i   (wb_pend),
    .hk_pend_i   (hk_req_i),
    .grant_o     (grant),
    .grant_hk_o  (grant_hk),
    .starve_cnt_o(starve_cnt)
  );

  always_comb begin
    wb_blk = wbs_adr_i[10 +: BSEL_W];
    hk_blk = hk_addr_i[SRAM_AW +: BSEL_W];
    if (RAM_BLOCKS == 1) begin
      wb_blk = '0;
      hk_blk = '0;
    end
    wb_onehot         = '0;
    wb_onehot[wb_blk] = 1'b1;
    hk_onehot         = '0;
    hk_onehot[hk_blk] = 1'b1;
    wb_mask                 = '0;
    wb_mask[4*wb_blk +: 4]  = wbs_sel_i;
    // A write with no lanes selected leaves the SRAM untouched entirely.
    wb_wr_null = wbs_we_i & (wbs_sel_i == 4'b0000);
    rdata_sel  = mem_rdata_i[32*blk_q +: 32];
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q        <= StIdle;
      blk_q          <= '0;
      we_q           <= 1'b0;
      owner_hk_q     <= 1'b0;
      wbs_ack_o      <= 1'b0;
      wbs_dat_o      <= '0;
      hk_valid_o     <= 1'b0;
      hk_rdata_o     <= '0;
      mem_ena_o      <= '0;
      mem_wen_o      <= '0;
      mem_wen_mask_o <= '0;
      mem_addr_o     <= '0;
      mem_wdata_o    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant) begin
            owner_hk_q <= grant_hk;
            state_q    <= StIssue;
            if (grant_hk) begin
              blk_q      <= hk_blk;
              we_q       <= 1'b0;
              mem_addr_o <= hk_addr_i[SRAM_AW-1:0];
              mem_ena_o  <= hk_onehot;
            end else begin
              blk_q       <= wb_blk;
              we_q        <= wbs_we_i;
              mem_addr_o  <= wbs_adr_i[9:2];
              mem_wdata_o <= wbs_dat_i;
              mem_ena_o   <= wb_wr_null ? '0 : wb_onehot;
              if (wbs_we_i && !wb_wr_null) begin
                mem_wen_o      <= wb_onehot;
                mem_wen_mask_o <= wb_mask;
              end
            end
          end
        end
        StIssue: begin
          mem_ena_o      <= '0;
          mem_wen_o      <= '0;
          mem_wen_mask_o <= '0;
          if (we_q) begin
            wbs_ack_o <= wbs_cyc_i;
            state_q   <= StResp;
          end else begin
            state_q <= StCapture;
          end
        end
        StCapture: begin
          if (owner_hk_q) begin
            hk_rdata_o <= rdata_sel;
            hk_valid_o <= 1'b1;
          end else begin
            wbs_dat_o <= rdata_sel;
            wbs_ack_o <= wbs_cyc_i;
          end
          state_q <= StResp;
        end
        StResp: begin
          wbs_ack_o  <= 1'b0;
          hk_valid_o <= 1'b0;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{wbs_adr_i, starve_cnt};

endmodule
